sweep_ctl: RTL and testbench

SWEEP_CTL -- requirements
Module: sweep_ctl

---
 rtl/sweep_ctl.sv | 198 +++++++++++++++++++
 tb/tb_sweep_ctl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctl.sv
// rtl/sweep_ctl.sv - frequency sweep sequencer feeding a DDS phase-increment word
module sweep_ctl #(
   parameter int FW = 32,
   parameter int DW = 20
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [FW-1:0] cfg_start,
   input  logic [FW-1:0] cfg_stop,
   input  logic [FW-1:0] cfg_step,
   input  logic [DW-1:0] cfg_dwell,
   input  logic [1:0]    cfg_mode,
   input  logic          start,
   input  logic          abort,
   output logic [FW-1:0] frq_word,
   output logic          frq_valid,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

   localparam logic [1:0] MODE_REPEAT = 2'b01;
   localparam logic [1:0] MODE_TRI    = 2'b10;

   // One step from cur toward target, evaluated one bit wider so nothing wraps.
   function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                 input logic [FW-1:0] stp,
                                                 input logic [FW-1:0] target,
                                                 input logic          up);
      logic [FW:0]   sum;
      logic [FW-1:0] diff;
      logic [FW-1:0] res;
      sum  = {1'b0, cur} + {1'b0, stp};
      diff = cur - stp;
      if (up) begin
         res = (sum >= {1'b0, target}) ? target : sum[FW-1:0];
      end else begin
         res = ((cur < stp) || (diff <= target)) ? target : diff;
      end
      return res;
   endfunction

   state_t        state_q, state_d;
   logic [FW-1:0] sh_start_q, sh_start_d;
   logic [FW-1:0] sh_stop_q, sh_stop_d;
   logic [FW-1:0] sh_step_q, sh_step_d;
   logic [DW-1:0] sh_dwell_q, sh_dwell_d;
   logic [1:0]    sh_mode_q, sh_mode_d;
   logic          loaded_q, loaded_d;
   logic          err_q, err_d;
   logic [FW-1:0] word_q, word_d;
   logic          valid_q, valid_d;
   // Run-time copies so a config accepted alongside start cannot disturb the sweep.
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [FW-1:0] step_q, step_d;
   logic [1:0]    mode_q, mode_d;
   logic          up_q, up_d;
   logic [FW-1:0] origin_q, origin_d;
   logic [FW-1:0] target_q, target_d;

   assign cfg_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_FIN);
   assign frq_word  = word_q;
   assign frq_valid = valid_q;
   assign err       = err_q;

   // Next-state, config capture, start qualification and word stepping.
   always_comb begin
      state_d    = state_q;
      sh_start_d = sh_start_q;
      sh_stop_d  = sh_stop_q;
      sh_step_d  = sh_step_q;
      sh_dwell_d = sh_dwell_q;
      sh_mode_d  = sh_mode_q;
      loaded_d   = loaded_q;
      err_d      = err_q;
      word_d     = word_q;
      valid_d    = 1'b0;
      cnt_d      = cnt_q;
      dwell_d    = dwell_q;
      step_d     = step_q;
      mode_d     = mode_q;
      up_d       = up_q;
      origin_d   = origin_q;
      target_d   = target_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               sh_start_d = cfg_start;
               sh_stop_d  = cfg_stop;
               sh_step_d  = cfg_step;
               sh_dwell_d = cfg_dwell;
               sh_mode_d  = cfg_mode;
               loaded_d   = 1'b1;
               err_d      = 1'b0;
            end
            // Start is qualified against the config already held, not the one arriving now.
            if (start && !abort) begin
               if (!loaded_q || ((sh_step_q == '0) && (sh_start_q != sh_stop_q))) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = ST_RUN;
                  word_d   = sh_start_q;
                  valid_d  = 1'b1;
                  cnt_d    = DW'(1);
                  dwell_d  = (sh_dwell_q == '0) ? DW'(1) : sh_dwell_q;
                  step_d   = sh_step_q;
                  mode_d   = sh_mode_q;
                  up_d     = (sh_stop_q >= sh_start_q);
                  origin_d = sh_start_q;
                  target_d = sh_stop_q;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q >= dwell_q) begin
               cnt_d = DW'(1);
               if (word_q == target_q) begin
                  case (mode_q)
                     MODE_REPEAT: begin
                        word_d  = origin_q;
                        valid_d = 1'b1;
                     end
                     MODE_TRI: begin
                        up_d     = !up_q;
                        origin_d = target_q;
                        target_d = origin_q;
                        word_d   = step_toward(word_q, step_q, origin_q, !up_q);
                        valid_d  = 1'b1;
                     end
                     default: state_d = ST_FIN;
                  endcase
               end else begin
                  word_d  = step_toward(word_q, step_q, target_q, up_q);
                  valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset clears everything including the shadow config.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         sh_start_q <= '0;
         sh_stop_q  <= '0;
         sh_step_q  <= '0;
         sh_dwell_q <= '0;
         sh_mode_q  <= '0;
         loaded_q   <= 1'b0;
         err_q      <= 1'b0;
         word_q     <= '0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
         dwell_q    <= '0;
         step_q     <= '0;
         mode_q     <= '0;
         up_q       <= 1'b0;
         origin_q   <= '0;
         target_q   <= '0;
      end else begin
         state_q    <= state_d;
         sh_start_q <= sh_start_d;
         sh_stop_q  <= sh_stop_d;
         sh_step_q  <= sh_step_d;
         sh_dwell_q <= sh_dwell_d;
         sh_mode_q  <= sh_mode_d;
         loaded_q   <= loaded_d;
         err_q      <= err_d;
         word_q     <= word_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         dwell_q    <= dwell_d;
         step_q     <= step_d;
         mode_q     <= mode_d;
         up_q       <= up_d;
         origin_q   <= origin_d;
         target_q   <= target_d;
      end
   end

endmodule

// File: tb/tb_sweep_ctl.sv
// tb/tb_sweep_ctl.sv - directed self-checking bench for sweep_ctl
module tb_sweep_ctl;

   logic        clk;
   logic        rstn;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_start;
   logic [31:0] cfg_stop;
   logic [31:0] cfg_step;
   logic [19:0] cfg_dwell;
   logic [1:0]  cfg_mode;
   logic        start;
   logic        abort;
   logic [31:0] frq_word;
   logic        frq_valid;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] got_w[$];
   int          got_t[$];
   int          busy_cnt;
   int          done_cnt;
   int          done_t;

   sweep_ctl #(.FW(32), .DW(20)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
      .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
      .start(start), .abort(abort),
      .frq_word(frq_word), .frq_valid(frq_valid),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [19:0] d, input logic [1:0] m);
      cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = d; cfg_mode = m;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Samples the current cycle first, then advances; stops on done if asked.
   task automatic observe(input int max_cyc, input bit stop_on_done);
      got_w.delete();
      got_t.delete();
      busy_cnt = 0;
      done_cnt = 0;
      done_t   = -1;
      for (int i = 0; i < max_cyc; i++) begin
         if (frq_valid) begin
            got_w.push_back(frq_word);
            got_t.push_back(i);
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_t = i;
            if (stop_on_done) break;
         end
         @(negedge clk);
      end
   endtask

   task automatic verify_words(input string tag, input int dwell);
      check({tag, "_pulses"}, got_w.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_w.size()) check($sformatf("%s_w%0d", tag, i), got_w[i], exp_q[i]);
      end
      for (int i = 1; i < got_t.size(); i++) begin
         check($sformatf("%s_gap%0d", tag, i), got_t[i] - got_t[i-1], dwell);
      end
   endtask

   task automatic verify_single(input string tag, input int dwell);
      observe(200, 1'b1);
      verify_words(tag, dwell);
      check({tag, "_busy"}, busy_cnt, exp_q.size() * dwell);
      check({tag, "_done"}, done_cnt, 1);
      check({tag, "_done_t"}, done_t, exp_q.size() * dwell);
      @(negedge clk);
      check({tag, "_ready_after"}, cfg_ready, 1'b1);
      check({tag, "_done_after"}, done, 1'b0);
      check({tag, "_word_after"}, frq_word, exp_q[exp_q.size()-1]);
   endtask

   initial begin
      rstn = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
      repeat (3) @(negedge clk);

      check("rst_word", frq_word, 0);
      check("rst_valid", frq_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ready", cfg_ready, 1);
      rstn = 1'b1;

      // Start with nothing loaded.
      pulse_start();
      check("noload_err", err, 1);
      check("noload_busy", busy, 0);

      // Single up sweep, dwell 3; config accepted right away clears err.
      load_cfg(32'd100, 32'd130, 32'd10, 20'd3, 2'b00);
      check("cfg_clears_err", err, 0);
      pulse_start();
      exp_q = '{32'd100, 32'd110, 32'd120, 32'd130};
      verify_single("single3", 3);

      // Clamp at stop, dwell 1.
      load_cfg(32'd0, 32'd25, 32'd10, 20'd1, 2'b00);
      pulse_start();
      exp_q = '{32'd0, 32'd10, 32'd20, 32'd25};
      verify_single("clamp", 1);

      // Top of range must not wrap; mode 11 acts as single.
      load_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 20'd1, 2'b11);
      pulse_start();
      exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
      verify_single("nowrap", 1);

      // Down sweep with step larger than current word; dwell 0 behaves as 1.
      load_cfg(32'd5, 32'd0, 32'd10, 20'd0, 2'b00);
      pulse_start();
      exp_q = '{32'd5, 32'd0};
      verify_single("down", 1);

      // start==stop single with zero step is legal.
      load_cfg(32'd7, 32'd7, 32'd0, 20'd2, 2'b00);
      pulse_start();
      exp_q = '{32'd7};
      verify_single("equal", 2);
      check("equal_err", err, 0);

      // Triangle, then abort while word is 20.
      load_cfg(32'd0, 32'd20, 32'd10, 20'd1, 2'b10);
      pulse_start();
      observe(6, 1'b0);
      exp_q = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10};
      verify_words("tri", 1);
      check("tri_no_done", done_cnt, 0);
      check("tri_word20", frq_word, 32'd20);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_ready", cfg_ready, 1);
      check("abort_word", frq_word, 32'd20);
      check("abort_done", done, 0);
      observe(4, 1'b0);
      check("abort_no_done_later", done_cnt, 0);
      check("abort_no_valid_later", got_w.size(), 0);

      // Zero step with distinct endpoints is a config error; good config clears it.
      load_cfg(32'd1, 32'd9, 32'd0, 20'd1, 2'b00);
      pulse_start();
      check("step0_err", err, 1);
      check("step0_busy", busy, 0);
      @(negedge clk);
      check("step0_sticky", err, 1);
      load_cfg(32'd100, 32'd130, 32'd10, 20'd3, 2'b00);
      check("step0_cleared", err, 0);

      // Config offered mid-sweep is refused and leaves the shadow copy intact.
      pulse_start();
      check("run_ready", cfg_ready, 0);
      load_cfg(32'd500, 32'd600, 32'd1, 20'd1, 2'b01);
      observe(200, 1'b1);
      check("midcfg_done", done_cnt, 1);
      check("midcfg_last", got_w.size() > 0 ? got_w[got_w.size()-1] : 32'hDEAD, 32'd130);
      @(negedge clk);
      pulse_start();
      exp_q = '{32'd100, 32'd110, 32'd120, 32'd130};
      verify_single("shadow_kept", 3);

      // Abort beats start in the same idle cycle.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("sa_busy", busy, 0);
      check("sa_valid", frq_valid, 0);
      check("sa_ready", cfg_ready, 1);

      // Repeat mode, then reset asynchronously mid-sweep.
      load_cfg(32'd10, 32'd30, 32'd10, 20'd2, 2'b01);
      pulse_start();
      observe(8, 1'b0);
      exp_q = '{32'd10, 32'd20, 32'd30, 32'd10};
      verify_words("repeat", 2);
      check("repeat_no_done", done_cnt, 0);
      check("repeat_busy", busy, 1);
      rstn = 1'b0;
      #1;
      check("mid_rst_word", frq_word, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", cfg_ready, 1);
      check("mid_rst_valid", frq_valid, 0);
      check("mid_rst_err", err, 0);
      rstn = 1'b1;
      @(negedge clk);
      pulse_start();
      check("post_rst_err", err, 1);
      check("post_rst_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
